uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the design's UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first, line idle high. It synchronises the asynchronous `rs232_rx` pin and generates its own bit timing from a parameterised divider. It presents each received byte on `rx_data` together with a busy/strobe pair. `rx_int` is high for the whole frame and falls when `rx_data` is valid, so the transmitter's falling-edge trigger can loop bytes straight back.

## Interface
- `CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate.
- Derived localparams:
  - `BIT_CYC = CLK_FREQ/BAUD_RATE` (integer division, must be ≥ 4).
  - `HALF_CYC = BIT_CYC/2`.
  - Counter width is `$clog2(BIT_CYC)`.
- `sys_clk`, input, 1: single clock; all logic on its rising edge.
- `sys_rst`, input, 1: reset, synchronous and active-high.
- `rs232_rx`, input, 1: asynchronous serial line.
- `rx_data`, output, 8: last correctly framed byte; holds until the next good frame.
- `rx_int`, output, 1: high while a frame is in progress; falls at end of frame.
- `rx_valid`, output, 1: one-cycle strobe, `rx_data` updated this cycle.
- `frame_err`, output, 1: one-cycle strobe, stop bit sampled low.

## Operation
- Input path:
  - 2-FF synchroniser, then a third register.
  - Falling edge `fall = s3 & ~s2` (s2 = synchroniser output, s3 = third register).
  - All three registers reset to 1.
- State machine: `IDLE`, `START`, `DATA`, `STOP`. One bit counter (0..BIT_CYC-1), one 3-bit index, one 8-bit shift register.
- IDLE:
  - `cnt` = 0, `rx_int` = 0.
  - On `fall`: go to START, set `rx_int` = 1.
- START:
  - Count to HALF_CYC-1, then sample `s2`.
  - Sample 0: go to DATA, clear `cnt` and index.
  - Sample 1: glitch. Go to IDLE, `rx_int` = 0, no strobe.
- DATA:
  - Sample `s2` each time `cnt` reaches BIT_CYC-1.
  - Shift right, new bit into bit 7, so the first received bit ends in bit 0.
  - After index 7, go to STOP.
- STOP: sample after BIT_CYC.
  - Sample 1: `rx_data` ← shift register, `rx_valid` = 1.
  - Sample 0: `frame_err` = 1, `rx_data` unchanged.
  - Either case: go to IDLE, `rx_int` = 0.
- Falling edges seen outside IDLE are ignored.
- After a framing error (including a break), a new frame needs a fresh high→low transition; a line held low does not retrigger.
- Counter is never free-running. It is cleared on every state entry, so bit timing re-anchors on each start edge.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_int` = 0, `rx_valid` = 0, `frame_err` = 0, state IDLE. Synchroniser registers = 1.
- Pin-to-detect: a falling edge on `rs232_rx` before edge k gives `fall` = 1 in cycle Td = k+2.
- `rx_int` rises at Td+1.
- Sample points, relative to Td:
  - Start bit: Td+HALF_CYC.
  - Data bit i (i = 0..7): Td+HALF_CYC+(i+1)·BIT_CYC.
  - Stop bit: Td+HALF_CYC+9·BIT_CYC.
- End of frame:
  - `rx_valid`/`frame_err` are high for exactly the cycle after the stop sample.
  - `rx_int` falls in that same cycle.
  - `rx_data` is valid from that cycle.
- Back-to-back frames: the next start edge may arrive any time after the stop sample (half a stop bit early). The block is in IDLE one cycle after the stop sample and accepts it.
- `sys_rst` mid-frame:
  - Next cycle: IDLE, outputs at reset values, partial byte discarded.
  - A line already low does not start a frame until it returns high and falls again.
- `rx_valid` and `frame_err` are never high together.

## Structure
- Shared package `uart_pkg`:
  - State enum (`IDLE`, `START`, `DATA`, `STOP`).
  - `UART_DATA_BITS` = 8.
  - Default `CLK_FREQ`/`BAUD_RATE`, shared with the transmitter.
- One sub-module, `uart_rx_sync`: 2-FF synchroniser plus edge register, outputs `s2` and `fall`, reset-to-1.
- Everything else is in `uart_rx`.

## Test plan
Bench parameters: `CLK_FREQ` = 1_600_000, `BAUD_RATE` = 100_000, so BIT_CYC = 16 and HALF_CYC = 8.
- Single frame 0xA5, idle line high:
  - `rx_int` high from Td+1.
  - `rx_valid` one cycle at Td+153.
  - `rx_data` = 8'hA5.
  - `rx_int` falls the same cycle.
  - `frame_err` = 0.
- Back-to-back 0x00, 0xFF, 0x55: three `rx_valid` strobes, values in order, no `frame_err`.
- Glitch: line low 4 cycles then high:
  - `rx_int` pulses about 8 cycles.
  - No `rx_valid` and no `frame_err`.
  - The next real frame 0x3C is received correctly.
- Stop bit forced low on 0x81:
  - `frame_err` one cycle, `rx_valid` 0.
  - `rx_data` keeps its previous value.
  - Line held low 40 cycles causes no new frame; the next 0x81 frame is received.
- `sys_rst` asserted for 1 cycle during data bit 4:
  - All outputs return to reset values next cycle.
  - No strobe for the aborted frame.
  - The following frame 0x7E is received.
- Baud tolerance: frames sent at ±3% bit period, random bytes: every byte received, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults for the receiver and transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 9600;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx pin synchroniser with falling-edge detect
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic s2_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic fresh_q, arm_q;

  // The reset-to-1 values are not real line history, so an edge only counts
  // once the pin itself has been seen high after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      fresh_q <= 1'b1;
      arm_q   <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fresh_q <= 1'b0;
      arm_q   <= arm_q | (s1_q & ~fresh_q);
    end
  end

  assign s2_o   = s2_q;
  assign fall_o = s3_q & ~s2_q & arm_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with busy/strobe outputs
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  uart_state_e state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      s2, fall;

  uart_rx_sync u_sync (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .rx_i   (rs232_rx),
    .s2_o   (s2),
    .fall_o (fall)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Counter restarts on every state entry, so timing re-anchors on each start edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {s2, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (s2) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_int    = (state_q != IDLE);
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule
